pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised fetch program-counter generator, the successor of the single-register PC.
- Computes the next PC internally: sequential, branch-relative, jump-region, register-indirect or exception vector.
- Holds fetch for a programmable number of cycles after reset and handshakes with the instruction memory.
- Buffers a redirect that arrives while fetch is stalled. Sits between the decode/execute redirect logic and the instruction memory port.

Parameters:
- WIDTH, 32, PC and address width in bits (>= 28).
- RESET_VECTOR, 32'h00003000, PC value loaded on reset.
- EXC_VECTOR, 32'h00004180, PC value loaded on exception request.
- RESET_HOLD, 2, cycles after reset deassertion before fetch_valid rises (0 allowed).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline stall; blocks PC advance.
- fetch_ready  in  1  instruction memory accepts the current PC.
- fetch_valid  out  1  PC is a valid fetch address.
- PC  out  WIDTH  current fetch address.
- redirect_valid  in  1  redirect request this cycle.
- redirect_kind  in  2  00 branch-relative, 01 jump-region, 10 register, 11 reserved.
- redirect_base  in  WIDTH  address of the redirecting instruction.
- redirect_imm  in  WIDTH  sign-extended word offset (00), 26-bit index in bits [25:0] (01), or target value (10).
- exc_req  in  1  exception request.
- exc_epc  out  WIDTH  PC captured on the last exception.
- redirect_pending  out  1  a buffered redirect is waiting.
- misalign  out  1  one-cycle pulse: a register target had nonzero bits [1:0].

Behaviour:
- Reset (async, rst=1):
  - PC=RESET_VECTOR, fetch_valid=0, exc_epc=0, redirect_pending=0, misalign=0.
  - Hold counter=RESET_HOLD.
  - State=HOLD, or RUN if RESET_HOLD=0.
- States:
  - HOLD: counter decrements every cycle; on the edge where it equals 1, go to RUN. fetch_valid=0 in HOLD, 1 in RUN. Exactly RESET_HOLD cycles of fetch_valid=0 after rst falls.
  - RUN: persists until reset. Reset mid-operation returns to HOLD and discards everything.
- advance = RUN & fetch_valid & fetch_ready & ~stall.
- Target computation, registered, all arithmetic mod 2^WIDTH:
  - 00: redirect_base + 4 + (redirect_imm << 2).
  - 01: {(redirect_base+4)[WIDTH-1:28], redirect_imm[25:0], 2'b00}.
  - 10: redirect_imm with bits [1:0] forced to 0. If the original bits [1:0] != 0, misalign=1 on the next cycle; otherwise misalign=0.
  - 11: ignored; no redirect and no pending update.
- Next-PC priority at each edge, in RUN:
  1. exc_req: PC<=EXC_VECTOR, exc_epc<=PC, redirect_pending<=0. Ignores stall and fetch_ready.
  2. advance & redirect_valid: PC<=live target, redirect_pending<=0.
  3. advance & redirect_pending: PC<=buffered target, redirect_pending<=0.
  4. advance: PC<=PC+4 (wraps at 2^WIDTH).
  5. ~advance & redirect_valid: buffer target, redirect_pending<=1. A newer redirect overwrites the buffer. PC holds.
  6. Otherwise PC holds.
- In HOLD: exc_req and redirects are ignored; PC stays RESET_VECTOR.
- PC stays stable while fetch_valid=1 & ~fetch_ready.
- misalign is low in every cycle not described above.

Test Plan:
- Reset/hold: RESET_HOLD=2, release rst, fetch_ready=1 -> fetch_valid 0,0 then 1; PC=0x3000, 0x3004, 0x3008 on successive cycles.
- Stall/backpressure: in RUN at PC=0x3008, stall=1 for 3 cycles -> PC holds 0x3008. Then fetch_ready=0 for 2 cycles -> PC still holds. Then advances to 0x300C.
- Branch and jump: base=0x3010, kind 00, imm=0xFFFFFFFE, advancing -> PC=0x300C. Then kind 01, imm=0x0000400 -> PC=0x00001000.
- Buffered redirect: stall=1, kind 10, imm=0x5000 -> redirect_pending=1, PC holds. Second redirect imm=0x6000 while still stalled -> overwrites buffer. Release stall -> PC=0x6000, pending=0.
- Exception priority: PC=0x3020, stall=1, exc_req=1 with a simultaneous redirect -> PC=0x4180, exc_epc=0x3020, pending=0.
- Misaligned register target and wrap: kind 10, imm=0x7003 -> PC=0x7000, misalign pulses one cycle. Separately, PC=0xFFFFFFFC advancing -> PC=0x00000000.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch program-counter generator: reset hold, sequential/branch/jump/register/exception
// next-PC selection, and a one-deep buffer for redirects that arrive while fetch is stalled.
module pc_gen #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_4180),
  parameter int               RESET_HOLD   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] PC,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_kind,
  input  logic [WIDTH-1:0] redirect_base,
  input  logic [WIDTH-1:0] redirect_imm,
  input  logic             exc_req,
  output logic [WIDTH-1:0] exc_epc,
  output logic             redirect_pending,
  output logic             misalign
);

  localparam int CW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD + 1) : 1;

  typedef enum logic {HOLD, RUN} state_e;
  localparam state_e RESET_STATE = (RESET_HOLD == 0) ? RUN : HOLD;

  state_e           state_q, state_d;
  logic [CW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             pend_q, pend_d;
  logic             mis_q, mis_d;

  logic [WIDTH-1:0] base_plus4;
  logic [WIDTH-1:0] region_tgt;
  logic [WIDTH-1:0] tgt;
  logic             tgt_misaligned;
  logic             redirect_ok;
  logic             running;
  logic             advance;

  assign running     = (state_q == RUN);
  // Gated by rst so fetch_valid is low during reset even when no hold is configured.
  assign fetch_valid = running & ~rst;
  assign advance     = running & fetch_valid & fetch_ready & ~stall;
  assign base_plus4  = redirect_base + WIDTH'(4);

  generate
    if (WIDTH > 28) begin : g_region_wide
      assign region_tgt = {base_plus4[WIDTH-1:28], redirect_imm[25:0], 2'b00};
    end else begin : g_region_narrow
      assign region_tgt = {redirect_imm[25:0], 2'b00};
    end
  endgenerate

  always_comb begin
    tgt            = pc_q;
    tgt_misaligned = 1'b0;
    case (redirect_kind)
      2'b00: tgt = base_plus4 + (redirect_imm << 2);
      2'b01: tgt = region_tgt;
      2'b10: begin
        tgt            = {redirect_imm[WIDTH-1:2], 2'b00};
        tgt_misaligned = |redirect_imm[1:0];
      end
      default: tgt = pc_q;
    endcase
  end

  assign redirect_ok = redirect_valid & (redirect_kind != 2'b11);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (state_q == HOLD) begin
      hold_d = hold_q - CW'(1);
      if (hold_q == CW'(1)) state_d = RUN;
    end
  end

  // Priority: exception, live redirect, buffered redirect, sequential, buffer a new redirect.
  always_comb begin
    pc_d   = pc_q;
    epc_d  = epc_q;
    buf_d  = buf_q;
    pend_d = pend_q;
    mis_d  = 1'b0;
    if (running) begin
      if (exc_req) begin
        pc_d   = EXC_VECTOR;
        epc_d  = pc_q;
        pend_d = 1'b0;
      end else if (advance && redirect_ok) begin
        pc_d   = tgt;
        pend_d = 1'b0;
        mis_d  = tgt_misaligned;
      end else if (advance && pend_q) begin
        pc_d   = buf_q;
        pend_d = 1'b0;
      end else if (advance) begin
        pc_d = pc_q + WIDTH'(4);
      end else if (redirect_ok) begin
        buf_d  = tgt;
        pend_d = 1'b1;
        mis_d  = tgt_misaligned;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
      hold_q  <= CW'(RESET_HOLD);
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      buf_q   <= '0;
      pend_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
    end
  end

  assign PC               = pc_q;
  assign exc_epc          = epc_q;
  assign redirect_pending = pend_q;
  assign misalign         = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic, each cycle
// compared against an arithmetic reference model of the next-PC rules.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] PC;
  logic        redirect_valid;
  logic [1:0]  redirect_kind;
  logic [31:0] redirect_base;
  logic [31:0] redirect_imm;
  logic        exc_req;
  logic [31:0] exc_epc;
  logic        redirect_pending;
  logic        misalign;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .PC(PC), .redirect_valid(redirect_valid),
    .redirect_kind(redirect_kind), .redirect_base(redirect_base),
    .redirect_imm(redirect_imm), .exc_req(exc_req), .exc_epc(exc_epc),
    .redirect_pending(redirect_pending), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc, m_buf;
  logic        m_pend, m_mis;
  int          m_hold;
  logic [66:0] obs, expv;

  function automatic logic [31:0] ref_target(input logic [1:0] kind, input logic [31:0] base,
                                             input logic [31:0] imm);
    case (kind)
      2'd0:    return base + 32'd4 + imm * 32'd4;
      2'd1:    return ((base + 32'd4) & 32'hF000_0000) | ((imm & 32'h03FF_FFFF) * 32'd4);
      default: return imm & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'h3000; m_epc = 0; m_buf = 0; m_pend = 0; m_mis = 0; m_hold = 2;
  endtask

  task automatic model_edge();
    logic        adv, rv;
    logic [31:0] t;
    logic        bad;
    m_mis = 0;
    if (m_hold > 0) begin
      m_hold = m_hold - 1;
      return;
    end
    adv = fetch_ready && !stall;
    rv  = redirect_valid && (redirect_kind != 2'd3);
    t   = ref_target(redirect_kind, redirect_base, redirect_imm);
    bad = (redirect_kind == 2'd2) && (redirect_imm % 4 != 0);
    if (exc_req) begin
      m_epc = m_pc; m_pc = 32'h4180; m_pend = 0;
    end else if (adv && rv) begin
      m_pc = t; m_pend = 0; m_mis = bad;
    end else if (adv && m_pend) begin
      m_pc = m_buf; m_pend = 0;
    end else if (adv) begin
      m_pc = m_pc + 32'd4;
    end else if (rv) begin
      m_buf = t; m_pend = 1; m_mis = bad;
    end
  endtask

  task automatic idle_inputs();
    stall = 0; fetch_ready = 1; redirect_valid = 0; redirect_kind = 0;
    redirect_base = 0; redirect_imm = 0; exc_req = 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #2;
    n_cmp++;
    if ({fetch_valid, PC, exc_epc, redirect_pending, misalign} !== {1'b0, 32'h3000, 32'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values: got fv=%0b pc=%h epc=%h pend=%0b mis=%0b, want 0/00003000/0/0/0",
               fetch_valid, PC, exc_epc, redirect_pending, misalign);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      obs  = {fetch_valid, PC, exc_epc, redirect_pending, misalign};
      expv = {m_hold == 0, m_pc, m_epc, m_pend, m_mis};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, expv);
      end else $display("reset_hold[%0d] fv=%0b pc=%h", i, fetch_valid, PC);
      if (i < 4) step();
    end
  endtask

  task automatic test_stall();
    logic [1:0] pat [6] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01}; // {stall, ready}
    for (int i = 0; i < 6; i++) begin
      {stall, fetch_ready} = pat[i];
      step();
      obs  = {fetch_valid, PC, exc_epc, redirect_pending, misalign};
      expv = {m_hold == 0, m_pc, m_epc, m_pend, m_mis};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL stall[%0d]: got %h want %h", i, obs, expv);
      end else $display("stall[%0d] stall=%0b ready=%0b pc=%h", i, stall, fetch_ready, PC);
    end
    n_cmp++;
    if (PC !== 32'h300C) begin
      n_bad++;
      $display("FAIL stall_final_pc: got %h want 0000300c", PC);
    end
    idle_inputs();
  endtask

  task automatic test_branch_jump();
    logic [1:0]  kinds [2] = '{2'd0, 2'd1};
    logic [31:0] bases [2] = '{32'h3010, 32'h300C};
    logic [31:0] imms  [2] = '{32'hFFFF_FFFE, 32'h0000_0400};
    logic [31:0] want  [2] = '{32'h300C, 32'h1000};
    for (int i = 0; i < 2; i++) begin
      redirect_valid = 1; redirect_kind = kinds[i]; redirect_base = bases[i]; redirect_imm = imms[i];
      step();
      n_cmp++;
      if (PC !== want[i] || m_pc !== want[i]) begin
        n_bad++;
        $display("FAIL branch_jump[%0d]: got pc=%h want %h", i, PC, want[i]);
      end else $display("branch_jump[%0d] kind=%0d pc=%h", i, kinds[i], PC);
    end
    idle_inputs();
  endtask

  task automatic test_buffered();
    logic [31:0] imms [2] = '{32'h5000, 32'h6000};
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      redirect_valid = (i < 2); redirect_kind = 2'd2; redirect_imm = imms[i % 2];
      if (i == 2) stall = 0;
      step();
      obs  = {fetch_valid, PC, exc_epc, redirect_pending, misalign};
      expv = {m_hold == 0, m_pc, m_epc, m_pend, m_mis};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL buffered[%0d]: got %h want %h", i, obs, expv);
      end else $display("buffered[%0d] pc=%h pend=%0b", i, PC, redirect_pending);
    end
    n_cmp++;
    if (PC !== 32'h6000 || redirect_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL buffered_final: got pc=%h pend=%0b want 00006000/0", PC, redirect_pending);
    end
    idle_inputs();
  endtask

  task automatic test_exception();
    redirect_valid = 1; redirect_kind = 2'd2; redirect_imm = 32'h3020;
    step();
    stall = 1; exc_req = 1; redirect_kind = 2'd0; redirect_base = 32'h100; redirect_imm = 32'h8;
    step();
    n_cmp++;
    if ({PC, exc_epc, redirect_pending} !== {32'h4180, 32'h3020, 1'b0} ||
        {m_pc, m_epc, m_pend} !== {32'h4180, 32'h3020, 1'b0}) begin
      n_bad++;
      $display("FAIL exception: got pc=%h epc=%h pend=%0b want 00004180/00003020/0",
               PC, exc_epc, redirect_pending);
    end else $display("exception pc=%h epc=%h", PC, exc_epc);
    idle_inputs();
  endtask

  task automatic test_misalign_wrap();
    logic [31:0] imms [4] = '{32'h7003, 32'h0, 32'hFFFF_FFFC, 32'h0};
    logic [32:0] want [4] = '{{32'h7000, 1'b1}, {32'h7004, 1'b0}, {32'hFFFF_FFFC, 1'b0}, {32'h0, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      redirect_valid = (i % 2 == 0); redirect_kind = 2'd2; redirect_imm = imms[i];
      step();
      n_cmp++;
      if ({PC, misalign} !== want[i] || {m_pc, m_mis} !== want[i]) begin
        n_bad++;
        $display("FAIL misalign_wrap[%0d]: got pc=%h mis=%0b want %h", i, PC, misalign, want[i]);
      end else $display("misalign_wrap[%0d] pc=%h mis=%0b", i, PC, misalign);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst = 1; #2;
        n_cmp++;
        if ({fetch_valid, PC, redirect_pending, misalign} !== {1'b0, 32'h3000, 1'b0, 1'b0}) begin
          n_bad++;
          $display("FAIL random_reset: got fv=%0b pc=%h pend=%0b mis=%0b", fetch_valid, PC,
                   redirect_pending, misalign);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 0;
      end
      stall          = ($urandom % 4 == 0);
      fetch_ready    = ($urandom % 4 != 0);
      redirect_valid = ($urandom % 3 == 0);
      redirect_kind  = 2'($urandom);
      redirect_base  = $urandom;
      redirect_imm   = ($urandom % 2) ? $urandom : ($urandom % 64) - 32;
      exc_req        = ($urandom % 24 == 0);
      step();
      obs  = {fetch_valid, PC, exc_epc, redirect_pending, misalign};
      expv = {m_hold == 0, m_pc, m_epc, m_pend, m_mis};
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, expv);
      end else $display("random[%0d] pc=%h pend=%0b mis=%0b", i, PC, redirect_pending, misalign);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch_jump();
    test_buffered();
    test_exception();
    test_misalign_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
